obstacle_collider: RTL and testbench

// Consumer end of the obstacle stream (valid/first_row/obstacle/done) produced once per frame after activate.

---
 rtl/obstacle_collider.sv | 161 ++++++++++++++++
 tb/tb_obstacle_collider.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/obstacle_collider.sv
// Consumer end of the per-frame obstacle stream: latches player state at activate, tests nearest-row
// beats in the player's lane, and reports collision / ground height / hit type once the stream ends.
module obstacle_collider #(
    parameter int PLAYER_DEPTH = 32,
    parameter int JUMP_CLEAR   = 16,
    parameter int TRAIN_HEIGHT = 64,
    parameter int STEP_TOL     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        activate,
    input  logic [1:0]  player_lane,
    input  logic [7:0]  player_height,
    input  logic        player_ducking,
    input  logic        valid,
    input  logic        first_row,
    input  logic [15:0] obstacle,
    input  logic        done,
    output logic        result_valid,
    output logic        collision,
    output logic [7:0]  ground_height,
    output logic [2:0]  hit_type,
    output logic [7:0]  obstacle_count,
    output logic        protocol_error
);
    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, REPORT} state_t;

    localparam logic [11:0] DEPTH_MIN = 12'(PLAYER_DEPTH);
    localparam logic [11:0] RAMP_END  = 12'(PLAYER_DEPTH + 128);
    localparam logic [7:0]  JUMP_H    = 8'(JUMP_CLEAR);
    localparam logic [7:0]  ROOF_H    = 8'(TRAIN_HEIGHT);
    localparam logic [7:0]  STEP_H    = 8'(TRAIN_HEIGHT - STEP_TOL);

    state_t      state, state_next;
    logic [1:0]  lane_q;
    logic [7:0]  height_q;
    logic        duck_q;

    logic        hit_q;
    logic [2:0]  type_q;
    logic [11:0] depth_q;

    logic        acc_coll, acc_gvalid;
    logic [7:0]  acc_ground, cnt_q;
    logic [2:0]  coll_type, ground_type;

    logic        beat_hit;
    logic [2:0]  beat_type;
    logic [11:0] beat_depth, beat_limit, ramp_off;
    logic        hit_coll;
    logic [7:0]  hit_ground;
    logic        acc_coll_n, acc_gvalid_n;
    logic [7:0]  acc_ground_n;
    logic [2:0]  coll_type_n, ground_type_n, res_type;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // activate restarts the frame from any state, taking priority over done
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (activate) state_next = COLLECT;
            COLLECT: if (activate) state_next = COLLECT;
                     else if (done) state_next = DRAIN;
            DRAIN:   state_next = activate ? COLLECT : REPORT;
            REPORT:  state_next = activate ? COLLECT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Stage 1: 12-bit window compare so PLAYER_DEPTH+LEN cannot wrap
    always_comb begin
        beat_type  = obstacle[15:13];
        beat_depth = {1'b0, obstacle[10:0]};
        beat_limit = DEPTH_MIN + (beat_type[2] ? 12'd128 : 12'd64);
        beat_hit   = valid && first_row && state == COLLECT && !activate
                  && obstacle[12:11] == lane_q
                  && beat_type != 3'b000 && beat_type != 3'b111
                  && beat_depth > DEPTH_MIN && beat_depth <= beat_limit;
    end

    // Stage 2: per-hit outcome, then fold into the frame accumulators
    always_comb begin
        hit_coll   = 1'b0;
        hit_ground = 8'd0;
        ramp_off   = RAMP_END - depth_q;
        case (type_q)
            3'b001: hit_coll = height_q < JUMP_H;
            3'b010: hit_coll = !duck_q;
            3'b011: hit_coll = height_q < JUMP_H && !duck_q;
            3'b100, 3'b110: begin
                if (height_q >= STEP_H) hit_ground = ROOF_H;
                else                    hit_coll   = 1'b1;
            end
            3'b101: hit_ground = 8'(ramp_off >> 1);
            default: ;
        endcase

        acc_coll_n    = acc_coll;
        acc_gvalid_n  = acc_gvalid;
        acc_ground_n  = acc_ground;
        coll_type_n   = coll_type;
        ground_type_n = ground_type;
        if (hit_q) begin
            if (hit_coll) begin
                if (!acc_coll) coll_type_n = type_q;
                acc_coll_n = 1'b1;
            end else if (!acc_gvalid || hit_ground > acc_ground) begin
                acc_gvalid_n  = 1'b1;
                acc_ground_n  = hit_ground;
                ground_type_n = type_q;
            end
        end
        res_type = acc_coll_n ? coll_type_n : (acc_gvalid_n ? ground_type_n : 3'b000);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q <= '0; height_q <= '0; duck_q <= 1'b0;
            hit_q <= 1'b0; type_q <= '0; depth_q <= '0;
            acc_coll <= 1'b0; acc_gvalid <= 1'b0; acc_ground <= '0;
            coll_type <= '0; ground_type <= '0; cnt_q <= '0;
        end else if (activate) begin
            lane_q <= player_lane; height_q <= player_height; duck_q <= player_ducking;
            hit_q <= 1'b0; type_q <= '0; depth_q <= '0;
            acc_coll <= 1'b0; acc_gvalid <= 1'b0; acc_ground <= '0;
            coll_type <= '0; ground_type <= '0; cnt_q <= '0;
        end else begin
            hit_q       <= beat_hit;
            type_q      <= beat_type;
            depth_q     <= beat_depth;
            acc_coll    <= acc_coll_n;
            acc_gvalid  <= acc_gvalid_n;
            acc_ground  <= acc_ground_n;
            coll_type   <= coll_type_n;
            ground_type <= ground_type_n;
            if (valid && state == COLLECT && cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
        end
    end

    // Result fields load on the DRAIN->REPORT edge, including the last in-flight hit
    always_ff @(posedge clk) begin
        if (rst) begin
            result_valid <= 1'b0; collision <= 1'b0; ground_height <= '0;
            hit_type <= '0; obstacle_count <= '0; protocol_error <= 1'b0;
        end else begin
            result_valid <= state == DRAIN && !activate;
            if (state == DRAIN && !activate) begin
                collision      <= acc_coll_n;
                ground_height  <= acc_ground_n;
                hit_type       <= res_type;
                obstacle_count <= cnt_q;
            end
            if ((valid && state != COLLECT) || (done && state == IDLE))
                protocol_error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_obstacle_collider.sv
// Directed bench for obstacle_collider: hand-computed frame results, latency, restart, reset and protocol checks.
module tb_obstacle_collider;
    logic        clk = 1'b0;
    logic        rst, activate, player_ducking, valid, first_row, done;
    logic [1:0]  player_lane;
    logic [7:0]  player_height;
    logic [15:0] obstacle;
    logic        result_valid, collision, protocol_error;
    logic [7:0]  ground_height, obstacle_count;
    logic [2:0]  hit_type;

    int n_cmp = 0;
    int n_bad = 0;
    logic [16:0] beats[$];

    obstacle_collider dut (
        .clk(clk), .rst(rst), .activate(activate), .player_lane(player_lane),
        .player_height(player_height), .player_ducking(player_ducking),
        .valid(valid), .first_row(first_row), .obstacle(obstacle), .done(done),
        .result_valid(result_valid), .collision(collision), .ground_height(ground_height),
        .hit_type(hit_type), .obstacle_count(obstacle_count), .protocol_error(protocol_error)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] bt(input logic fr, input logic [2:0] t,
                                       input logic [1:0] l, input logic [10:0] d);
        return {fr, t, l, d};
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_fields(input string tag, input logic ec, input logic [7:0] eg,
                              input logic [2:0] et, input logic [7:0] en);
        chk({tag, " collision"}, 16'(collision), 16'(ec));
        chk({tag, " ground"}, 16'(ground_height), 16'(eg));
        chk({tag, " hit_type"}, 16'(hit_type), 16'(et));
        chk({tag, " count"}, 16'(obstacle_count), 16'(en));
    endtask

    // Plays the queued beats as one frame; player inputs are scrambled after activate to prove latching.
    task automatic frame(input string tag, input logic [1:0] ln, input logic [7:0] h, input logic dk,
                         input bit done_with_last, input logic ec, input logic [7:0] eg,
                         input logic [2:0] et, input logic [7:0] en);
        @(negedge clk);
        activate = 1'b1; player_lane = ln; player_height = h; player_ducking = dk;
        @(negedge clk);
        activate = 1'b0; player_lane = ~ln; player_height = ~h; player_ducking = ~dk;
        foreach (beats[i]) begin
            valid = 1'b1;
            {first_row, obstacle} = beats[i];
            done = done_with_last && (i == beats.size() - 1);
            @(negedge clk);
        end
        valid = 1'b0; first_row = 1'b0; obstacle = '0;
        if (!done_with_last || beats.size() == 0) begin
            done = 1'b1;
            @(negedge clk);
        end
        done = 1'b0;
        chk({tag, " rv_drain"}, 16'(result_valid), 16'd0);
        @(negedge clk);
        chk({tag, " rv_report"}, 16'(result_valid), 16'd1);
        chk_fields(tag, ec, eg, et, en);
        @(negedge clk);
        chk({tag, " rv_after"}, 16'(result_valid), 16'd0);
        chk_fields({tag, " hold"}, ec, eg, et, en);
        beats.delete();
    endtask

    initial begin
        rst = 1'b1; activate = 1'b0; player_lane = '0; player_height = '0; player_ducking = 1'b0;
        valid = 1'b0; first_row = 1'b0; obstacle = '0; done = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset rv", 16'(result_valid), 16'd0);
        chk("reset perr", 16'(protocol_error), 16'd0);
        chk_fields("reset", 1'b0, 8'd0, 3'd0, 8'd0);

        beats.push_back(bt(1, 3'b001, 2'd1, 11'd40));
        frame("jump_low", 2'd1, 8'd0, 1'b0, 0, 1'b1, 8'd0, 3'b001, 8'd1);
        beats.push_back(bt(1, 3'b001, 2'd1, 11'd40));
        frame("jump_clear", 2'd1, 8'd20, 1'b0, 0, 1'b0, 8'd0, 3'b001, 8'd1);
        beats.push_back(bt(1, 3'b010, 2'd1, 11'd40));
        frame("duck_ok", 2'd1, 8'd0, 1'b1, 0, 1'b0, 8'd0, 3'b010, 8'd1);

        beats.push_back(bt(1, 3'b100, 2'd0, 11'd100));
        frame("train_roof", 2'd0, 8'd64, 1'b0, 0, 1'b0, 8'd64, 3'b100, 8'd1);
        beats.push_back(bt(1, 3'b100, 2'd0, 11'd100));
        frame("train_hit", 2'd0, 8'd50, 1'b0, 0, 1'b1, 8'd0, 3'b100, 8'd1);
        beats.push_back(bt(1, 3'b100, 2'd0, 11'd100));
        frame("train_step", 2'd0, 8'd56, 1'b0, 1, 1'b0, 8'd64, 3'b100, 8'd1);

        beats.push_back(bt(1, 3'b101, 2'd2, 11'd128));
        frame("ramp", 2'd2, 8'd0, 1'b0, 0, 1'b0, 8'd16, 3'b101, 8'd1);
        beats.push_back(bt(1, 3'b101, 2'd2, 11'd128));
        beats.push_back(bt(1, 3'b001, 2'd2, 11'd40));
        frame("ramp_jump", 2'd2, 8'd0, 1'b0, 1, 1'b1, 8'd16, 3'b001, 8'd2);

        // window edges: 32 outside, 96 inside for short types, 97 outside; 160 last ramp depth
        beats.push_back(bt(1, 3'b001, 2'd1, 11'd32));
        beats.push_back(bt(1, 3'b001, 2'd1, 11'd97));
        beats.push_back(bt(1, 3'b100, 2'd1, 11'd161));
        frame("edges_out", 2'd1, 8'd0, 1'b0, 0, 1'b0, 8'd0, 3'b000, 8'd3);
        beats.push_back(bt(1, 3'b011, 2'd1, 11'd96));
        frame("edge96", 2'd1, 8'd0, 1'b0, 0, 1'b1, 8'd0, 3'b011, 8'd1);
        beats.push_back(bt(1, 3'b101, 2'd1, 11'd160));
        beats.push_back(bt(1, 3'b110, 2'd1, 11'd160));
        frame("edge160", 2'd1, 8'd60, 1'b0, 0, 1'b0, 8'd64, 3'b110, 8'd2);

        for (int i = 0; i < 16; i++) beats.push_back(bt(1, 3'b001, 2'd0, 11'd40));
        for (int i = 0; i < 16; i++) beats.push_back(bt(1, 3'b001, 2'd1, 11'd200));
        for (int i = 0; i < 16; i++) beats.push_back(bt(0, 3'b001, 2'd1, 11'd40));
        frame("misses", 2'd1, 8'd0, 1'b0, 0, 1'b0, 8'd0, 3'b000, 8'd48);

        for (int i = 0; i < 300; i++) beats.push_back(bt(1, 3'b111, 2'd1, 11'd40));
        frame("saturate", 2'd1, 8'd0, 1'b0, 0, 1'b0, 8'd0, 3'b000, 8'd255);

        // restart: a hit in the aborted frame must not leak into the next result
        @(negedge clk);
        activate = 1'b1; player_lane = 2'd1; player_height = 8'd0; player_ducking = 1'b0;
        @(negedge clk);
        activate = 1'b0; valid = 1'b1; first_row = 1'b1; obstacle = 16'(bt(1, 3'b001, 2'd1, 11'd40));
        @(negedge clk);
        valid = 1'b0; first_row = 1'b0; obstacle = '0;
        frame("restart", 2'd1, 8'd0, 1'b0, 0, 1'b0, 8'd0, 3'b000, 8'd0);
        chk("no spurious perr", 16'(protocol_error), 16'd0);

        // reset mid-COLLECT clears fields and produces no result
        beats.push_back(bt(1, 3'b100, 2'd0, 11'd100));
        frame("pre_rst", 2'd0, 8'd64, 1'b0, 0, 1'b0, 8'd64, 3'b100, 8'd1);
        @(negedge clk);
        activate = 1'b1; player_lane = 2'd1; player_height = 8'd0;
        @(negedge clk);
        activate = 1'b0; valid = 1'b1; first_row = 1'b1; obstacle = 16'(bt(1, 3'b001, 2'd1, 11'd40));
        @(negedge clk);
        valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("rst_mid rv", 16'(result_valid), 16'd0);
            @(negedge clk);
        end
        chk_fields("rst_mid", 1'b0, 8'd0, 3'd0, 8'd0);

        // valid outside a frame sets the sticky error
        valid = 1'b1; first_row = 1'b1; obstacle = 16'(bt(1, 3'b001, 2'd0, 11'd40));
        @(negedge clk);
        valid = 1'b0; first_row = 1'b0;
        chk("perr set", 16'(protocol_error), 16'd1);
        beats.push_back(bt(1, 3'b001, 2'd0, 11'd40));
        frame("after_perr", 2'd0, 8'd0, 1'b0, 0, 1'b1, 8'd0, 3'b001, 8'd1);
        chk("perr sticky", 16'(protocol_error), 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
